pipeline_sequencer: RTL

Central stall/flush controller for the 5-stage pipeline of one core. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their advance enables and flush requests from memory-hit, load-use, redirect and halt conditions. It latches partial memory completions, so an instruction hit and a data hit arriving in different cycles still produce exactly one advance. It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipeline_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller for the 5-stage pipeline.
// Generates the PC and stage-register advance enables plus the IF/ID and
// ID/EX flush requests from the memory-hit, load-use, redirect and halt
// conditions. Hits that arrive in different cycles are latched, so each
// instruction still advances exactly once. Stall and flush counters
// saturate and are kept for performance debug.
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   ihit, dhit            instruction / data access complete
//   dmem_req_MEM          MEM-stage instruction accesses memory
//   MemRead_EX, wsel_EX   EX-stage load and its destination register
//   rs1_ID, rs2_ID, use_* ID-stage source registers and their use flags
//   redirect_EX           taken branch/jump resolved in EX
//   is_halt_MEM           halt instruction in MEM
//   pc_en, en_*           PC load and stage-register advance enables
//   flush_IF_ID/ID_EX     zero the register on its next advance
//   halt                  sticky core-halted flag
//   stall_cnt, flush_cnt  saturating performance counters
module pipeline_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_MEM,
  input  logic             MemRead_EX,
  input  logic [4:0]       wsel_EX,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic             redirect_EX,
  input  logic             is_halt_MEM,
  output logic             pc_en,
  output logic             en_IF_ID,
  output logic             en_ID_EX,
  output logic             en_EX_MEM,
  output logic             en_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, WAIT, HALT} state_t;

  state_t           state_q, state_d;
  logic             ihit_q, ihit_d;
  logic             dhit_q, dhit_d;
  logic             halt_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             i_done, d_done, adv, load_use;

  // Completion of the current slot, including hits latched in earlier cycles.
  assign i_done   = ihit | ihit_q;
  assign d_done   = !dmem_req_MEM | dhit | dhit_q;
  assign adv      = i_done & d_done & (state_q != HALT);
  assign load_use = MemRead_EX & (wsel_EX != 5'd0) &
                    ((use_rs1_ID & (rs1_ID == wsel_EX)) |
                     (use_rs2_ID & (rs2_ID == wsel_EX)));

  // Next state, enables, flushes and counter increments.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    en_IF_ID    = 1'b0;
    en_ID_EX    = 1'b0;
    en_EX_MEM   = 1'b0;
    en_MEM_WB   = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!RST && state_q != HALT) begin
      if (!adv) begin
        state_d   = WAIT;
        stall_inc = 1'b1;
      end else if (is_halt_MEM) begin
        // Drain MEM and WB only; ID/EX receives nothing this cycle.
        en_EX_MEM = 1'b1;
        en_MEM_WB = 1'b1;
        state_d   = HALT;
        stall_inc = 1'b1;
      end else if (redirect_EX) begin
        // Redirect overrides load-use: the ID instruction is wrong-path.
        pc_en       = 1'b1;
        en_IF_ID    = 1'b1;
        en_ID_EX    = 1'b1;
        en_EX_MEM   = 1'b1;
        en_MEM_WB   = 1'b1;
        flush_IF_ID = 1'b1;
        flush_ID_EX = 1'b1;
        state_d     = RUN;
        stall_inc   = 1'b1;
        flush_inc   = 1'b1;
      end else if (load_use) begin
        // Hold IF and ID, insert a bubble into EX.
        en_ID_EX    = 1'b1;
        en_EX_MEM   = 1'b1;
        en_MEM_WB   = 1'b1;
        flush_ID_EX = 1'b1;
        state_d     = RUN;
        stall_inc   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        en_IF_ID  = 1'b1;
        en_ID_EX  = 1'b1;
        en_EX_MEM = 1'b1;
        en_MEM_WB = 1'b1;
        state_d   = RUN;
      end
    end
  end

  // Hit latches hold partial completions until the slot advances.
  assign ihit_d = adv ? 1'b0 : (ihit_q | ihit);
  assign dhit_d = adv ? 1'b0 : (dhit_q | dhit);

  // State, latches, halt flag and saturating counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      ihit_q      <= 1'b0;
      dhit_q      <= 1'b0;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      halt_q  <= (state_d == HALT);
      if (stall_inc && stall_cnt_q != {CNT_W{1'b1}})
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && flush_cnt_q != {CNT_W{1'b1}})
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
